// File: rtl/rx_byte_unstriping.sv
// -----------------------------------------------------------------------------
// rx_byte_unstriping
//
// Receive-side byte unstriper. Four 8-bit lanes arrive with independent
// byte-valid strobes and possibly different skews. Each lane has its own
// deskew FIFO. A lane starts filling its FIFO when it first sees the COM
// symbol (the lane "locks"). Once all four FIFO heads show COM, the block
// is ALIGNED. From then on it pops one byte from every lane at a time and
// re-serialises them as lane 0,1,2,3 on successive clocks.
//
// Optional feature (macro RX_STRIP_SKP_EN):
//   defined   - serialiser slots carrying SKP_SYM are emitted with
//               rx_ValidS=0; slot timing is unchanged.
//   undefined - SKP_SYM is passed through like any other byte.
//
// Parameters:
//   DESKEW_DEPTH  entries per lane FIFO (power of two, >= 2)
//   COM_SYM       alignment symbol (K28.5)
//   SKP_SYM       skip symbol (K28.0)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   enb            global enable; low freezes all state and drops lane input
//   rx_lane0..3    lane bytes
//   rx_lane_valid  per-lane byte-valid strobe (bit n for lane n)
//   rx_DataS       re-serialised byte
//   rx_ValidS      rx_DataS valid
//   aligned        high while in ALIGNED
//   deskew_err     one-cycle pulse when a lane FIFO overflows
// -----------------------------------------------------------------------------
module rx_byte_unstriping #(
  parameter int unsigned DESKEW_DEPTH = 4,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic [3:0] rx_lane_valid,
  output logic [7:0] rx_DataS,
  output logic       rx_ValidS,
  output logic       aligned,
  output logic       deskew_err
);

  // Address bits index the storage; the extra pointer MSB tells a full
  // FIFO (MSBs differ, low bits equal) from an empty one (all bits equal).
  localparam int unsigned AW = $clog2(DESKEW_DEPTH);
  localparam int unsigned PW = AW + 1;

`ifdef RX_STRIP_SKP_EN
  localparam bit SKP_STRIP = 1'b1;
`else
  localparam bit SKP_STRIP = 1'b0;
`endif

  typedef enum logic {
    SEARCH  = 1'b0,
    ALIGNED = 1'b1
  } state_t;

  state_t        state;

  logic [7:0]    lane_byte [4];
  logic [7:0]    fifo_mem  [4][DESKEW_DEPTH];
  logic [PW-1:0] wr_ptr    [4];
  logic [PW-1:0] rd_ptr    [4];
  logic [3:0]    lock;

  // Serialiser: the hold register keeps the popped group, slot is the lane
  // index currently shown on rx_DataS, busy marks a group in flight.
  logic [7:0]    hold      [4];
  logic [1:0]    slot;
  logic          busy;

  logic [7:0]    fifo_head [4];
  logic [3:0]    fifo_empty;
  logic [3:0]    fifo_full;
  logic [3:0]    head_com;
  logic [3:0]    lane_wr;
  logic          pop;
  logic          overflow;
  logic          go_aligned;

  assign lane_byte[0] = rx_lane0;
  assign lane_byte[1] = rx_lane1;
  assign lane_byte[2] = rx_lane2;
  assign lane_byte[3] = rx_lane3;

  // A serialiser slot is flagged valid unless SKP stripping is built in
  // and the slot carries the skip symbol.
  function automatic logic slot_valid(input logic [7:0] b);
    return !(SKP_STRIP && (b == SKP_SYM));
  endfunction

  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    head_com   = '0;
    lane_wr    = '0;
    for (int n = 0; n < 4; n++) begin
      fifo_head[n]  = fifo_mem[n][rd_ptr[n][AW-1:0]];
      fifo_empty[n] = (wr_ptr[n] == rd_ptr[n]);
      fifo_full[n]  = (wr_ptr[n][AW] != rd_ptr[n][AW]) &&
                      (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
      head_com[n]   = !fifo_empty[n] && (fifo_head[n] == COM_SYM);
      // In SEARCH an unlocked lane only accepts the COM that locks it.
      lane_wr[n]    = enb && rx_lane_valid[n] &&
                      ((state == ALIGNED) || lock[n] || (lane_byte[n] == COM_SYM));
    end

    // Pop a whole group when the serialiser is idle or showing its last
    // slot, so consecutive groups stream without a bubble.
    pop        = enb && (state == ALIGNED) && (!busy || (slot == 2'd3)) &&
                 (fifo_empty == 4'b0000);

    // Pops are common to all lanes, so a same-cycle pop frees room on
    // every full FIFO being written.
    overflow   = (|(lane_wr & fifo_full)) && !pop;

    go_aligned = enb && (state == SEARCH) && (lock == 4'hF) && (head_com == 4'hF);
  end

  // FIFO storage has no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (lane_wr[n]) begin
        fifo_mem[n][wr_ptr[n][AW-1:0]] <= lane_byte[n];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      lock       <= '0;
      slot       <= '0;
      busy       <= 1'b0;
      rx_DataS   <= '0;
      rx_ValidS  <= 1'b0;
      aligned    <= 1'b0;
      deskew_err <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        hold[n]   <= '0;
      end
    end else if (!enb) begin
      rx_ValidS  <= 1'b0;
      deskew_err <= 1'b0;
    end else if (overflow) begin
      // Flush everything and start the alignment search again; whatever
      // was left in the hold register is abandoned.
      state      <= SEARCH;
      lock       <= '0;
      slot       <= '0;
      busy       <= 1'b0;
      rx_ValidS  <= 1'b0;
      aligned    <= 1'b0;
      deskew_err <= 1'b1;
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end
    end else begin
      deskew_err <= 1'b0;

      for (int n = 0; n < 4; n++) begin
        if (lane_wr[n]) begin
          wr_ptr[n] <= wr_ptr[n] + PW'(1);
          lock[n]   <= 1'b1;
        end
        if (pop) begin
          rd_ptr[n] <= rd_ptr[n] + PW'(1);
        end
      end

      if (go_aligned) begin
        state   <= ALIGNED;
        aligned <= 1'b1;
      end

      // Lane 0 goes straight from the FIFO head to the output so it
      // appears one cycle after the pop; lanes 1..3 follow from hold.
      if (pop) begin
        hold      <= fifo_head;
        slot      <= 2'd0;
        busy      <= 1'b1;
        rx_DataS  <= fifo_head[0];
        rx_ValidS <= slot_valid(fifo_head[0]);
      end else if (busy && (slot != 2'd3)) begin
        slot      <= slot + 2'd1;
        rx_DataS  <= hold[slot + 2'd1];
        rx_ValidS <= slot_valid(hold[slot + 2'd1]);
      end else begin
        busy      <= 1'b0;
        rx_ValidS <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_byte_unstriping.sv
// -----------------------------------------------------------------------------
// tb_rx_byte_unstriping
//
// Directed bench for rx_byte_unstriping (DESKEW_DEPTH=4). A negedge monitor
// logs every valid output byte with its cycle number and counts deskew_err
// cycles; each test compares the logged stream against a hand-written
// expected byte list and the expected first-to-last cycle span.
// Honours RX_STRIP_SKP_EN for the skip-symbol test.
// -----------------------------------------------------------------------------
module tb_rx_byte_unstriping;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [7:0] rx_lane0, rx_lane1, rx_lane2, rx_lane3;
  logic [3:0] rx_lane_valid;
  logic [7:0] rx_DataS;
  logic       rx_ValidS;
  logic       aligned;
  logic       deskew_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int err_pulses = 0;

  logic [7:0] out_q [$];
  int         cyc_q [$];
  logic [7:0] exp_q [$];

  rx_byte_unstriping #(
    .DESKEW_DEPTH (4),
    .COM_SYM      (8'hBC),
    .SKP_SYM      (8'h1C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .rx_lane0      (rx_lane0),
    .rx_lane1      (rx_lane1),
    .rx_lane2      (rx_lane2),
    .rx_lane3      (rx_lane3),
    .rx_lane_valid (rx_lane_valid),
    .rx_DataS      (rx_DataS),
    .rx_ValidS     (rx_ValidS),
    .aligned       (aligned),
    .deskew_err    (deskew_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampling mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_ValidS) begin
        out_q.push_back(rx_DataS);
        cyc_q.push_back(cyc);
      end
      if (deskew_err) err_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] v,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    @(negedge clk);
    enb           = en;
    rx_lane_valid = v;
    rx_lane0      = b0;
    rx_lane1      = b1;
    rx_lane2      = b2;
    rx_lane3      = b3;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    enb           = 1'b0;
    rx_lane_valid = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // COM group then two data groups, one valid beat every 4th cycle.
  task automatic zeroSkew();
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h00, 8'h01, 8'h02, 8'h03);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h04, 8'h05, 8'h06, 8'h07);
    idle(8);
  endtask

  task automatic loadCase1();
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h00, 8'h01, 8'h02, 8'h03,
              8'h04, 8'h05, 8'h06, 8'h07};
  endtask

  // Compares monitor log entries from index base onward against exp_q.
  task automatic checkStream(input string tag, input int base, input int span);
    int n;
    n = out_q.size() - base;
    checkOutput({tag, " count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checkOutput($sformatf("%s byte%0d", tag, i), out_q[base + i], exp_q[i]);
    end
    if (n > 0) checkOutput({tag, " span"}, cyc_q[base + n - 1] - cyc_q[base], span);
  endtask

  initial begin
    int base;
    int ebase;

    rst           = 1'b1;
    enb           = 1'b0;
    rx_lane_valid = 4'h0;
    rx_lane0      = 8'h00;
    rx_lane1      = 8'h00;
    rx_lane2      = 8'h00;
    rx_lane3      = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset rx_DataS",   rx_DataS,   8'h00);
    checkOutput("reset rx_ValidS",  rx_ValidS,  1'b0);
    checkOutput("reset aligned",    aligned,    1'b0);
    checkOutput("reset deskew_err", deskew_err, 1'b0);
    rst = 1'b0;

    // Test 1: zero skew
    $display("[TB] test 1 zero skew");
    base  = out_q.size();
    ebase = err_pulses;
    zeroSkew();
    loadCase1();
    checkStream("T1", base, 11);
    checkOutput("T1 aligned", aligned, 1'b1);
    checkOutput("T1 err", err_pulses - ebase, 0);

    // Test 2: lane 2 lags by two beats behind two 0x55 fillers
    $display("[TB] test 2 skew");
    doReset();
    base  = out_q.size();
    ebase = err_pulses;
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'h55, 8'hBC);
    applyStimulus(1'b1, 4'hF, 8'h00, 8'h01, 8'h55, 8'h03);
    applyStimulus(1'b1, 4'hF, 8'h04, 8'h05, 8'hBC, 8'h07);
    applyStimulus(1'b1, 4'h4, 8'h00, 8'h00, 8'h02, 8'h00);
    applyStimulus(1'b1, 4'h4, 8'h00, 8'h00, 8'h06, 8'h00);
    idle(16);
    checkStream("T2", base, 11);
    checkOutput("T2 err", err_pulses - ebase, 0);
    checkOutput("T2 aligned", aligned, 1'b1);

    // Test 3: lane 3 COM four beats late overflows the depth-4 FIFOs
    $display("[TB] test 3 excess skew");
    doReset();
    base  = out_q.size();
    ebase = err_pulses;
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'h55);
    applyStimulus(1'b1, 4'hF, 8'h00, 8'h01, 8'h02, 8'h55);
    applyStimulus(1'b1, 4'hF, 8'h04, 8'h05, 8'h06, 8'h55);
    applyStimulus(1'b1, 4'hF, 8'h08, 8'h09, 8'h0A, 8'h55);
    applyStimulus(1'b1, 4'hF, 8'h0C, 8'h0D, 8'h0E, 8'hBC);
    idle(4);
    checkOutput("T3 err pulses", err_pulses - ebase, 1);
    checkOutput("T3 aligned", aligned, 1'b0);
    checkOutput("T3 valid count", out_q.size() - base, 0);
    base = out_q.size();
    zeroSkew();
    loadCase1();
    checkStream("T3 recover", base, 11);

    // Test 4: enb low for 3 cycles mid-stream; lane data offered meanwhile is dropped
    $display("[TB] test 4 enable pause");
    doReset();
    base = out_q.size();
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h00, 8'h01, 8'h02, 8'h03);
    applyStimulus(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 4'hF, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    applyStimulus(1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 4'hF, 8'h04, 8'h05, 8'h06, 8'h07);
    idle(12);
    loadCase1();
    checkStream("T4", base, 14);

    // Test 5: reset while lane 1 of the first data group is on the output
    $display("[TB] test 5 reset mid-group");
    doReset();
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h00, 8'h01, 8'h02, 8'h03);
    idle(3);
    @(negedge clk);
    #1;
    checkOutput("T5 pre data",  rx_DataS,  8'h01);
    checkOutput("T5 pre valid", rx_ValidS, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("T5 rx_DataS",   rx_DataS,   8'h00);
    checkOutput("T5 rx_ValidS",  rx_ValidS,  1'b0);
    checkOutput("T5 aligned",    aligned,    1'b0);
    checkOutput("T5 deskew_err", deskew_err, 1'b0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = out_q.size();
    zeroSkew();
    loadCase1();
    checkStream("T5 recover", base, 11);

    // Test 6: an all-SKP group after alignment
    $display("[TB] test 6 skip group");
    doReset();
    base = out_q.size();
    applyStimulus(1'b1, 4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h1C, 8'h1C, 8'h1C, 8'h1C);
    idle(3);
    applyStimulus(1'b1, 4'hF, 8'h04, 8'h05, 8'h06, 8'h07);
    idle(8);
`ifdef RX_STRIP_SKP_EN
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h04, 8'h05, 8'h06, 8'h07};
`else
    exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h1C,
              8'h04, 8'h05, 8'h06, 8'h07};
`endif
    checkStream("T6", base, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
